fifo_wr_arbiter: RTL

//  Round-robin burst arbiter sharing the write port of one syn_fifo among NUM_REQ producers.

---
 rtl/fifo_wr_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Round-robin burst arbiter that shares one syn_fifo write port
//             among NUM_REQ producers, with stall on FIFO full.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            ack_o,
    output logic [NUM_REQ-1:0]            grant_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_cs_o,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_in_o,
    output logic                          busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [IDX_W:0]     c_NUM_REQ   = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0]   c_LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]   c_LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [NUM_REQ-1:0] c_ONE       = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     owner_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [CNT_W-1:0]     burst_cnt_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic                 busy_q;
    logic                 wr_cs_q;

    logic [IDX_W:0]       w_idx;
    logic [IDX_W-1:0]     w_pick;
    logic                 w_pick_vld;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic [IDX_W-1:0]     w_owner_nxt;
    logic                 w_in_grant;
    logic                 w_owner_req;
    logic                 w_wr_en;

    // Scan from the highest offset down so the entry closest to rr_ptr wins.
    always_comb begin
        w_idx      = '0;
        w_pick     = '0;
        w_pick_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (w_idx >= c_NUM_REQ) begin
                w_idx = w_idx - c_NUM_REQ;
            end
            if (req_i[w_idx[IDX_W-1:0]]) begin
                w_pick     = w_idx[IDX_W-1:0];
                w_pick_vld = 1'b1;
            end
        end
    end

    assign w_pick_oh   = c_ONE << w_pick;
    assign w_owner_nxt = (owner_q == c_LAST_IDX) ? '0 : owner_q + 1'b1;
    assign w_in_grant  = (state_q == ST_GRANT);
    assign w_owner_req = req_i[owner_q];
    assign w_wr_en     = w_in_grant & w_owner_req & ~fifo_full_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            wr_cs_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        state_q     <= ST_GRANT;
                        owner_q     <= w_pick;
                        burst_cnt_q <= '0;
                        grant_q     <= w_pick_oh;
                        busy_q      <= 1'b1;
                        wr_cs_q     <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    // A dropped request or the last beat of a burst releases the port.
                    if (!w_owner_req || (w_wr_en && (burst_cnt_q == c_LAST_BEAT))) begin
                        state_q     <= ST_IDLE;
                        rr_ptr_q    <= w_owner_nxt;
                        burst_cnt_q <= '0;
                        grant_q     <= '0;
                        busy_q      <= 1'b0;
                        wr_cs_q     <= 1'b0;
                    end else if (w_wr_en) begin
                        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_o        = grant_q;
    assign busy_o         = busy_q;
    assign fifo_wr_cs_o   = wr_cs_q;
    assign fifo_wr_en_o   = w_wr_en;
    assign ack_o          = grant_q & {NUM_REQ{w_wr_en}};
    assign fifo_data_in_o = w_in_grant ? req_data_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH]
                                       : '0;

endmodule
`default_nettype wire
